// File: rtl/nn_arb_pkg.sv
// Shared types and constants for the two-requester layer-engine arbiter.
package nn_arb_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, SEND, RECV} arb_state_t;

  typedef logic req_id_t;

  // Index of the owner encoded in a one-hot two-bit grant.
  function automatic req_id_t owner_of(input logic [NUM_REQ-1:0] g);
    return g[1];
  endfunction

endpackage

// File: rtl/nn_layer_arbiter_if.sv
// Requester-side and engine-side handshake bundle of nn_layer_arbiter.
interface nn_layer_arbiter_if
  import nn_arb_pkg::*;
#(
  parameter int unsigned W = 16
);

  logic [NUM_REQ-1:0] s_valid;
  logic [NUM_REQ-1:0] s_ready;
  logic [W-1:0]       s_data0;
  logic [W-1:0]       s_data1;
  logic [NUM_REQ-1:0] m_valid;
  logic [NUM_REQ-1:0] m_ready;
  logic [W-1:0]       m_data;
  logic               eng_s_valid;
  logic               eng_s_ready;
  logic [W-1:0]       eng_s_data;
  logic               eng_m_valid;
  logic               eng_m_ready;
  logic [W-1:0]       eng_m_data;

  // Arbiter side.
  modport slave (
    input  s_valid, s_data0, s_data1, m_ready, eng_s_ready, eng_m_valid, eng_m_data,
    output s_ready, m_valid, m_data, eng_s_valid, eng_s_data, eng_m_ready
  );

  // Requesters plus engine side.
  modport master (
    output s_valid, s_data0, s_data1, m_ready, eng_s_ready, eng_m_valid, eng_m_data,
    input  s_ready, m_valid, m_data, eng_s_valid, eng_s_data, eng_m_ready
  );

endinterface

// File: rtl/nn_rr_pick.sv
// Combinational two-way round-robin picker; pointer names the preferred requester on a tie.
module nn_rr_pick
  import nn_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            pointer,
  output logic [NUM_REQ-1:0] winner
);

  always_comb begin
    winner = '0;
    case (req)
      2'b01:   winner = 2'b01;
      2'b10:   winner = 2'b10;
      2'b11:   winner = pointer ? 2'b10 : 2'b01;
      default: winner = '0;
    endcase
  end

endmodule

// File: rtl/nn_layer_arbiter.sv
// Grants one layer engine to one of two requesters for a whole N-in / M-out vector transaction.
// Optional NN_ARB_PERF_CNT_EN adds saturating per-requester completed-transaction counters.
module nn_layer_arbiter
  import nn_arb_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned M = 4,
  parameter int unsigned W = 16
) (
  input  logic               clk,
  input  logic               reset,
  nn_layer_arbiter_if.slave  bus,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy
`ifdef NN_ARB_PERF_CNT_EN
  ,
  output logic [15:0]        vec_cnt0,
  output logic [15:0]        vec_cnt1
`endif
);

  localparam int unsigned InW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OutW = (M > 1) ? $clog2(M) : 1;

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q;
  req_id_t            ptr_q;
  logic [InW-1:0]     in_cnt_q, in_cnt_d;
  logic [OutW-1:0]    out_cnt_q, out_cnt_d;

  logic [NUM_REQ-1:0] win;
  req_id_t            owner;
  logic               grant_en;
  logic               last_out;

  logic [NUM_REQ-1:0] s_ready, m_valid;
  logic [W-1:0]       m_data, eng_s_data;
  logic               eng_s_valid, eng_m_ready;

  nn_rr_pick u_pick (
    .req     (bus.s_valid),
    .pointer (ptr_q),
    .winner  (win)
  );

  assign owner = owner_of(grant_q);

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    grant_en    = 1'b0;
    last_out    = 1'b0;
    s_ready     = '0;
    m_valid     = '0;
    m_data      = '0;
    eng_s_valid = 1'b0;
    eng_s_data  = '0;
    eng_m_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.s_valid) begin
          grant_en = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        eng_s_valid    = bus.s_valid[owner];
        eng_s_data     = owner ? bus.s_data1 : bus.s_data0;
        s_ready[owner] = bus.eng_s_ready;
        if (eng_s_valid && bus.eng_s_ready) begin
          if (in_cnt_q == InW'(N - 1)) begin
            in_cnt_d = '0;
            state_d  = RECV;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      RECV: begin
        m_valid[owner] = bus.eng_m_valid;
        m_data         = bus.eng_m_data;
        eng_m_ready    = bus.m_ready[owner];
        if (bus.eng_m_valid && eng_m_ready) begin
          if (out_cnt_q == OutW'(M - 1)) begin
            out_cnt_d = '0;
            last_out  = 1'b1;
            state_d   = IDLE;
          end else begin
            out_cnt_d = out_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= 1'b0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      if (grant_en) begin
        grant_q <= win;
      end else if (last_out) begin
        // Hand the tie-break to the requester that just waited.
        grant_q <= '0;
        ptr_q   <= ~owner;
      end
    end
  end

`ifdef NN_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      vec_cnt0 <= '0;
      vec_cnt1 <= '0;
    end else if (last_out) begin
      if (!owner && vec_cnt0 != 16'hFFFF) vec_cnt0 <= vec_cnt0 + 16'd1;
      if (owner && vec_cnt1 != 16'hFFFF)  vec_cnt1 <= vec_cnt1 + 16'd1;
    end
  end
`endif

  assign grant           = grant_q;
  assign busy            = (state_q != IDLE);
  assign bus.s_ready     = s_ready;
  assign bus.m_valid     = m_valid;
  assign bus.m_data      = m_data;
  assign bus.eng_s_valid = eng_s_valid;
  assign bus.eng_s_data  = eng_s_data;
  assign bus.eng_m_ready = eng_m_ready;

endmodule

// File: tb/tb_nn_layer_arbiter.sv
// Self-checking bench for nn_layer_arbiter: transaction-level model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nn_layer_arbiter;
  import nn_arb_pkg::*;

  localparam int unsigned N = 8;
  localparam int unsigned M = 4;
  localparam int unsigned W = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant;
  logic       busy;
`ifdef NN_ARB_PERF_CNT_EN
  logic [15:0] vec_cnt0, vec_cnt1;
`endif

  nn_layer_arbiter_if #(.W(W)) bus ();

  nn_layer_arbiter #(.N(N), .M(M), .W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .grant    (grant),
    .busy     (busy)
`ifdef NN_ARB_PERF_CNT_EN
    ,
    .vec_cnt0 (vec_cnt0),
    .vec_cnt1 (vec_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Model: owner (-1 idle), words moved so far in this transaction, tie-break pointer, completions.
  int own = -1;
  int n_in = 0;
  int n_out = 0;
  int ptr = 0;
  int pc[2] = '{0, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Outputs are a function of the model's view of the transaction plus current inputs.
  task automatic settle();
    logic [1:0]   e_sr, e_mv, e_gr;
    logic         e_esv, e_emr, e_busy;
    logic [W-1:0] e_esd, e_md;
    #1;
    e_sr = '0; e_mv = '0; e_gr = '0; e_esv = 0; e_emr = 0; e_busy = 0; e_esd = '0; e_md = '0;
    if (own >= 0) begin
      e_busy = 1;
      e_gr   = (own == 0) ? 2'b01 : 2'b10;
      if (n_in < N) begin
        e_esv     = bus.s_valid[own];
        e_esd     = (own == 1) ? bus.s_data1 : bus.s_data0;
        e_sr[own] = bus.eng_s_ready;
      end else begin
        e_mv[own] = bus.eng_m_valid;
        e_md      = bus.eng_m_data;
        e_emr     = bus.m_ready[own];
      end
    end
    check("grant", grant, e_gr);
    check("busy", busy, e_busy);
    check("s_ready", bus.s_ready, e_sr);
    check("eng_s_valid", bus.eng_s_valid, e_esv);
    check("eng_s_data", bus.eng_s_data, e_esd);
    check("m_valid", bus.m_valid, e_mv);
    check("m_data", bus.m_data, e_md);
    check("eng_m_ready", bus.eng_m_ready, e_emr);
`ifdef NN_ARB_PERF_CNT_EN
    check("vec_cnt0", vec_cnt0, pc[0]);
    check("vec_cnt1", vec_cnt1, pc[1]);
`endif
  endtask

  task automatic advance();
    if (reset) begin
      own = -1; n_in = 0; n_out = 0; ptr = 0; pc[0] = 0; pc[1] = 0;
    end else if (own < 0) begin
      if (bus.s_valid != 2'b00)
        own = (bus.s_valid == 2'b11) ? ptr : (bus.s_valid[1] ? 1 : 0);
    end else if (n_in < N) begin
      if (bus.s_valid[own] && bus.eng_s_ready) n_in++;
    end else if (bus.eng_m_valid && bus.m_ready[own]) begin
      n_out++;
      if (n_out == M) begin
        if (pc[own] < 65535) pc[own]++;
        ptr = 1 - own;
        own = -1; n_in = 0; n_out = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.s_valid = '0; bus.m_ready = '0; bus.eng_s_ready = 1'b0; bus.eng_m_valid = 1'b0;
    settle();
    advance();
    reset = 1'b0;
  endtask

  initial begin
    int lit_in, lit_out, rc, w, hold, gapc, nt, idle;
    int owners[5];
    int gaps[5];

    bus.s_valid = '0; bus.s_data0 = '0; bus.s_data1 = '0; bus.m_ready = '0;
    bus.eng_s_ready = 1'b0; bus.eng_m_valid = 1'b0; bus.eng_m_data = '0;
    @(posedge clk);
    #1;
    do_reset();
    check("rst_grant", grant, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_s_ready", bus.s_ready, 2'b00);

    // Single requester: words 1..8 in, results 10,20,30,40 out.
    lit_in = 0; lit_out = 0;
    for (int c = 0; c < 60 && lit_out < M; c++) begin
      bus.s_valid = 2'b01; bus.s_data0 = W'(lit_in + 1); bus.s_data1 = 16'h7777;
      bus.eng_s_ready = 1'b1; bus.eng_m_valid = 1'b1; bus.eng_m_data = W'(10 * (lit_out + 1));
      bus.m_ready = 2'b01;
      settle();
      if (bus.eng_s_valid && bus.eng_s_ready) begin
        check("t1_in_word", bus.eng_s_data, lit_in + 1);
        lit_in++;
      end
      if (bus.m_valid[0] && bus.m_ready[0]) begin
        check("t1_result", bus.m_data, 10 * (lit_out + 1));
        lit_out++;
      end
      if (busy) check("t1_grant", grant, 2'b01);
      advance();
    end
    check("t1_words_in", lit_in, N);
    check("t1_words_out", lit_out, M);
    bus.s_valid = 2'b11;
    settle();
    check("t1_idle_after", busy, 1'b0);
    advance();
    settle();
    check("t1_ptr_grant", grant, 2'b10);
    advance();
    do_reset();

    // Contention from reset: five transactions alternate 0,1,0,1,0 with one idle cycle between.
    nt = 0; idle = 0; rc = 0;
    for (int c = 0; c < 400 && rc < 5 * M; c++) begin
      bus.s_valid = 2'b11; bus.s_data0 = W'($urandom); bus.s_data1 = W'($urandom);
      bus.eng_s_ready = 1'b1; bus.eng_m_valid = 1'b1; bus.eng_m_data = W'($urandom);
      bus.m_ready = 2'b11;
      settle();
      if (busy && nt < 5 && (nt == 0 || idle > 0)) begin
        owners[nt] = grant; gaps[nt] = idle; nt++;
      end
      idle = busy ? 0 : idle + 1;
      if ((bus.m_valid & bus.m_ready) != 2'b00) rc++;
      advance();
    end
    check("t2_txns", nt, 5);
    for (int k = 0; k < nt; k++) begin
      check("t2_owner", owners[k], (k % 2 == 0) ? 1 : 2);
      if (k > 0) check("t2_gap", gaps[k], 1);
    end
`ifdef NN_ARB_PERF_CNT_EN
    check("t2_vec_cnt0", vec_cnt0, 3);
    check("t2_vec_cnt1", vec_cnt1, 2);
    do_reset();
    check("t2_vec_cnt0_rst", vec_cnt0, 0);
    check("t2_vec_cnt1_rst", vec_cnt1, 0);
`else
    do_reset();
`endif

    // Backpressure: engine input ready toggles; requester 0 stalls results for 5 cycles.
    hold = 0; rc = 0;
    for (int c = 0; c < 200 && rc < M; c++) begin
      bus.s_valid = 2'b01; bus.s_data0 = W'($urandom);
      bus.eng_s_ready = c[0]; bus.eng_m_valid = 1'b1; bus.eng_m_data = W'($urandom);
      if (own == 0 && n_in == N && hold < 5) begin
        bus.m_ready = 2'b00; hold++;
      end else begin
        bus.m_ready = 2'b01;
      end
      settle();
      if (own == 0 && n_in == N && !bus.m_ready[0])
        check("t3_eng_m_ready_held", bus.eng_m_ready, 1'b0);
      if (bus.m_valid[0] && bus.m_ready[0]) rc++;
      advance();
    end
    check("t3_results", rc, M);
    check("t3_hold_cycles", hold, 5);
    do_reset();

    // Gap: requester 1 drops valid for 3 cycles after word 4.
    w = 0; gapc = 0; rc = 0;
    for (int c = 0; c < 100 && rc < M; c++) begin
      if (w == 4 && gapc < 3) begin
        bus.s_valid = 2'b00; gapc++;
      end else begin
        bus.s_valid = 2'b10;
      end
      bus.s_data1 = W'($urandom); bus.eng_s_ready = 1'b1;
      bus.eng_m_valid = 1'b1; bus.eng_m_data = W'($urandom); bus.m_ready = 2'b10;
      settle();
      if (bus.s_valid == 2'b00) check("t4_busy_in_gap", {busy, grant}, 3'b110);
      if (bus.s_valid[1] && bus.s_ready[1]) w++;
      if (bus.m_valid[1] && bus.m_ready[1]) rc++;
      advance();
    end
    check("t4_words", w, N);
    check("t4_results", rc, M);
    do_reset();

    // Reset mid-SEND after 5 words, then requester 1 alone.
    w = 0;
    for (int c = 0; c < 40 && w < 5; c++) begin
      bus.s_valid = 2'b01; bus.s_data0 = W'($urandom); bus.eng_s_ready = 1'b1;
      settle();
      if (bus.s_ready[0]) w++;
      advance();
    end
    check("t5_words_before_reset", w, 5);
    reset = 1'b1;
    settle();
    advance();
    reset = 1'b0;
    bus.s_valid = 2'b10;
    settle();
    check("t5_grant_after_reset", grant, 2'b00);
    check("t5_busy_after_reset", busy, 1'b0);
    check("t5_s_ready_after_reset", bus.s_ready, 2'b00);
    advance();
    settle();
    check("t5_grant_req1", grant, 2'b10);
    advance();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 599) == 0);
      bus.s_valid = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      bus.s_data0 = W'($urandom); bus.s_data1 = W'($urandom);
      bus.eng_s_ready = ($urandom_range(0, 9) < 7);
      bus.eng_m_valid = ($urandom_range(0, 9) < 6);
      bus.eng_m_data = W'($urandom);
      bus.m_ready = {($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7)};
      settle();
      advance();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
